gen_clock_multi: RTL
====================

GEN_CLOCK_MULTI -- requirements
Module: gen_clock_multi

Interface
REQ-001 Parameter NUM_OUT, default 3: number of power-of-two divided outputs, range 1..16.
REQ-002 Parameter DW, default 8: width of the programmable half-period value.
REQ-003 Parameter DEF_HALF, default 0: programmable half-period value loaded at reset.
REQ-004 clk  input  1: single clock; all state updates on posedge clk.
REQ-005 reset  input  1: asynchronous, active-low reset; a low level clears state immediately, independent of clk.
REQ-006 en  input  1: count enable; 0 freezes all dividers.
REQ-007 div_val  input  DW: requested half-period minus one for clk_prog.
REQ-008 div_load  input  1: one-cycle strobe that captures div_val.
REQ-009 clk_div  output  NUM_OUT: registered divided clocks; bit i = clk/2^(i+1), 50% duty.
REQ-010 tick  output  NUM_OUT: registered one-cycle strobes; bit i marks the rising edge of clk_div[i].
REQ-011 clk_prog  output  1: registered programmable clock, period 2*(half+1) clk cycles, 50% duty.
REQ-012 div_pend  output  1: high while a captured divisor waits to be applied.

Function
REQ-013 The block SHALL keep an NUM_OUT-bit down-counter cnt, decremented by 1 modulo 2^NUM_OUT on each posedge where en=1, and SHALL drive clk_div = cnt (registered, no decode).
REQ-014 Wrap: cnt = 0 SHALL decrement to all-ones, so clk_div[i] toggles whenever cnt[i-1:0] = 0 before the edge; bit 0 toggles every enabled cycle.
REQ-015 tick[i] SHALL be 1 for exactly the cycle following an edge where clk_div[i] went 0->1, and 0 otherwise.
REQ-016 With en=0: cnt, clk_div, clk_prog and the half-period counter SHALL hold, and tick SHALL be all-zeros.
REQ-017 The block SHALL hold an active half-period register half (DW bits) and a down-counter pcnt (DW bits).
REQ-018 On each enabled edge: if pcnt = 0, clk_prog toggles and pcnt reloads; otherwise pcnt decrements by 1.
REQ-019 Reload value: if clk_prog = 1 before the edge (a full period is ending) and div_pend = 1, half <= pend_val, pcnt <= pend_val, and div_pend clears; otherwise pcnt <= half.
REQ-020 div_load = 1 SHALL capture div_val into pend_val and set div_pend on that edge, regardless of en.
REQ-021 A div_load while div_pend = 1 SHALL overwrite pend_val; only the last value is applied.
REQ-022 If div_load coincides with the apply edge, the apply SHALL use the old pend_val, and the new value SHALL stay pending (div_pend remains 1).
REQ-023 A divisor change SHALL take effect only at a clk_prog 1->0 boundary; no high or low phase SHALL be shorter than min(old, new) half+1 cycles.
REQ-024 div_val = 0 SHALL be legal and gives clk_prog = clk/2.

Reset
REQ-025 While reset = 0: cnt = 0, clk_div = 0, tick = 0, clk_prog = 0, half = DEF_HALF, pcnt = DEF_HALF, pend_val = 0, div_pend = 0.
REQ-026 Reset assertion mid-operation SHALL clear all state asynchronously, including any pending divisor.
REQ-027 After reset deassertion, the first enabled edge SHALL produce clk_div = all-ones and tick = all-ones.

Verification
REQ-028 NUM_OUT=3, en=1, release reset -> clk_div sequence 111, 110, 101, 100, 011, 010, 001, 000, 111; tick = 111 after the first edge, then tick[0] every 2 cycles, tick[1] every 4, tick[2] every 8.
REQ-029 en=0 for 5 cycles mid-sequence at clk_div = 101 -> clk_div holds 101, tick = 000, clk_prog frozen; resumes at 100 when en=1.
REQ-030 DEF_HALF=0, div_val=2, div_load pulsed while clk_prog=0 -> div_pend=1; the current period finishes at 1 cycle per phase, then clk_prog runs 3 high / 3 low and div_pend=0 from the apply edge.
REQ-031 div_load 5 then div_load 1 before the boundary -> only half=1 is applied (2 high / 2 low); value 5 is never observed.
REQ-032 div_load on the apply edge -> the old pending value is applied and div_pend stays 1; the new value is applied at the following 1->0 boundary.
REQ-033 reset pulsed low asynchronously between clk edges with div_pend=1 -> all outputs 0 immediately, div_pend=0, clk_prog restarts at DEF_HALF.

Source files
------------

// File: rtl/gen_clock_multi.sv
// Clock generator: a free-running down-counter whose bits are power-of-two divided
// clocks, plus one programmable-period clock whose divisor changes only at a period boundary.
module gen_clock_multi #(
    parameter int NUM_OUT  = 3,
    parameter int DW       = 8,
    parameter int DEF_HALF = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [DW-1:0]      div_val,
    input  logic               div_load,
    output logic [NUM_OUT-1:0] clk_div,
    output logic [NUM_OUT-1:0] tick,
    output logic               clk_prog,
    output logic               div_pend
);

    logic [NUM_OUT-1:0] cnt_q, cnt_d;
    logic [NUM_OUT-1:0] tick_q, tick_d;
    logic               prog_q, prog_d;
    logic [DW-1:0]      half_q, half_d;
    logic [DW-1:0]      pcnt_q, pcnt_d;
    logic [DW-1:0]      pend_val_q, pend_val_d;
    logic               pend_q, pend_d;
    logic               apply;

    // A new divisor is applied only when a high phase ends, so a phase is never cut short.
    assign apply = en && (pcnt_q == '0) && prog_q && pend_q;

    always_comb begin
        cnt_d      = cnt_q;
        tick_d     = '0;
        prog_d     = prog_q;
        half_d     = half_q;
        pcnt_d     = pcnt_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;

        if (en) begin
            cnt_d  = cnt_q - NUM_OUT'(1);
            // Rising bits of the counter become next cycle's strobes.
            tick_d = ~cnt_q & cnt_d;
            if (pcnt_q == '0) begin
                prog_d = ~prog_q;
                if (apply) begin
                    half_d = pend_val_q;
                    pcnt_d = pend_val_q;
                    pend_d = 1'b0;
                end else begin
                    pcnt_d = half_q;
                end
            end else begin
                pcnt_d = pcnt_q - DW'(1);
            end
        end

        // A load on the apply edge wins the pending flag; the apply above used the old value.
        if (div_load) begin
            pend_val_d = div_val;
            pend_d     = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q      <= '0;
            tick_q     <= '0;
            prog_q     <= 1'b0;
            half_q     <= DW'(DEF_HALF);
            pcnt_q     <= DW'(DEF_HALF);
            pend_val_q <= '0;
            pend_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            tick_q     <= tick_d;
            prog_q     <= prog_d;
            half_q     <= half_d;
            pcnt_q     <= pcnt_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
        end
    end

    assign clk_div  = cnt_q;
    assign tick     = tick_q;
    assign clk_prog = prog_q;
    assign div_pend = pend_q;

endmodule
